// File: rtl/logic_op_pkg.sv
// Shared opcode constants, FSM state encoding and opcode legality for logic_op_responder.
// Build option: LOGIC_OP_XOR_EN makes OP_XORXNOR a legal opcode.
package logic_op_pkg;

  localparam logic [1:0] OP_ANDOR   = 2'd0;
  localparam logic [1:0] OP_NANDNOR = 2'd1;
  localparam logic [1:0] OP_XORXNOR = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic op_legal(input logic [1:0] op);
`ifdef LOGIC_OP_XOR_EN
    return (op == OP_ANDOR) || (op == OP_NANDNOR) || (op == OP_XORXNOR);
`else
    return (op == OP_ANDOR) || (op == OP_NANDNOR);
`endif
  endfunction

endpackage

// File: rtl/logic_bit_slice.sv
// Single-bit combinational logic unit: primary and complementary result for one operand bit pair.
// Build option: LOGIC_OP_XOR_EN adds the XOR/XNOR pair.
module logic_bit_slice
  import logic_op_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic [1:0] op,
  output logic       x_bit,
  output logic       y_bit
);

  always_comb begin
    x_bit = 1'b0;
    y_bit = 1'b0;
    case (op)
      OP_ANDOR: begin
        x_bit = a & b;
        y_bit = a | b;
      end
      OP_NANDNOR: begin
        x_bit = ~(a & b);
        y_bit = ~(a | b);
      end
`ifdef LOGIC_OP_XOR_EN
      OP_XORXNOR: begin
        x_bit = a ^ b;
        y_bit = ~(a ^ b);
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/logic_op_responder.sv
// Bit-serial logic-op responder: accepts one request, evaluates it LSB first, holds the response until taken.
// Build option: LOGIC_OP_XOR_EN enables the XOR/XNOR opcode.
module logic_op_responder
  import logic_op_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [1:0]       req_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_x,
  output logic [WIDTH-1:0] rsp_y,
  output logic             rsp_err
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_q, b_q, x_q, y_q;
  logic [1:0]       op_q;
  logic             err_q;
  logic             x_bit, y_bit;
  logic             last_bit;

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  logic_bit_slice u_slice (
    .a     (a_q[cnt]),
    .b     (b_q[cnt]),
    .op    (op_q),
    .x_bit (x_bit),
    .y_bit (y_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = op_legal(req_op) ? BUSY : DONE;
      BUSY:    if (last_bit)  state_nxt = DONE;
      DONE:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == DONE);
  end

  // Operands are captured only on acceptance, so request-side activity in BUSY/DONE cannot disturb them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      x_q   <= '0;
      y_q   <= '0;
      err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          a_q  <= req_a;
          b_q  <= req_b;
          op_q <= req_op;
          cnt  <= '0;
          if (op_legal(req_op)) begin
            err_q <= 1'b0;
          end else begin
            err_q <= 1'b1;
            x_q   <= '0;
            y_q   <= '0;
          end
        end
        BUSY: begin
          x_q[cnt] <= x_bit;
          y_q[cnt] <= y_bit;
          cnt      <= last_bit ? '0 : cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign rsp_x   = x_q;
  assign rsp_y   = y_q;
  assign rsp_err = err_q;

endmodule

// File: tb/tb_logic_op_responder.sv
// Directed self-checking bench for logic_op_responder (WIDTH=4); latency counts include the acceptance edge.
module tb_logic_op_responder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_a, req_b;
  logic [1:0] req_op;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_x, rsp_y;
  logic       rsp_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  logic_op_responder #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_x     (rsp_x),
    .rsp_y     (rsp_y),
    .rsp_err   (rsp_err)
  );

  // Issue one request from IDLE and wait (bounded) for the response; edges counts the acceptance edge as 1.
  task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                       output int edges, output logic [3:0] x, output logic [3:0] y, output logic err);
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    req_op    = op;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_a     = ~a;
    req_b     = ~b;
    req_op    = op ^ 2'b01;
    edges = 1;
    while (!rsp_valid && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    x   = rsp_x;
    y   = rsp_y;
    err = rsp_err;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    checks++;
    if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
    checks++;
    if (rsp_x !== 4'b0000 || rsp_y !== 4'b0000) begin
      errors++; $display("FAIL reset_rsp_xy: got x=%b y=%b want 0000/0000", rsp_x, rsp_y);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_andor();
    int n; logic [3:0] x, y; logic e;
    do_op(4'b0110, 4'b1010, 2'd0, n, x, y, e);
    checks++;
    if (n !== 5) begin errors++; $display("FAIL andor_latency: got %0d want 5", n); end
    checks++;
    if (x !== 4'b0010 || y !== 4'b1110 || e !== 1'b0) begin
      errors++; $display("FAIL andor_result: got x=%b y=%b err=%b want 0010/1110/0", x, y, e);
    end
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL andor_return_idle: got ready=%b valid=%b want 1/0", req_ready, rsp_valid);
    end
    do_op(4'b1111, 4'b0101, 2'd0, n, x, y, e);
    checks++;
    if (x !== 4'b0101 || y !== 4'b1111 || e !== 1'b0) begin
      errors++; $display("FAIL andor_result2: got x=%b y=%b err=%b want 0101/1111/0", x, y, e);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_nandnor();
    int n; logic [3:0] x, y; logic e;
    do_op(4'b0110, 4'b1010, 2'd1, n, x, y, e);
    checks++;
    if (n !== 5) begin errors++; $display("FAIL nandnor_latency: got %0d want 5", n); end
    checks++;
    if (x !== 4'b1101 || y !== 4'b0001 || e !== 1'b0) begin
      errors++; $display("FAIL nandnor_result: got x=%b y=%b err=%b want 1101/0001/0", x, y, e);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_xorxnor();
    int n; logic [3:0] x, y; logic e;
    do_op(4'b0110, 4'b1010, 2'd2, n, x, y, e);
`ifdef LOGIC_OP_XOR_EN
    checks++;
    if (n !== 5) begin errors++; $display("FAIL xor_latency: got %0d want 5", n); end
    checks++;
    if (x !== 4'b1100 || y !== 4'b0011 || e !== 1'b0) begin
      errors++; $display("FAIL xor_result: got x=%b y=%b err=%b want 1100/0011/0", x, y, e);
    end
`else
    checks++;
    if (n !== 1) begin errors++; $display("FAIL xor_disabled_latency: got %0d want 1", n); end
    checks++;
    if (x !== 4'b0000 || y !== 4'b0000 || e !== 1'b1) begin
      errors++; $display("FAIL xor_disabled_result: got x=%b y=%b err=%b want 0000/0000/1", x, y, e);
    end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_illegal();
    int n; logic [3:0] x, y; logic e;
    do_op(4'b1111, 4'b1111, 2'd3, n, x, y, e);
    checks++;
    if (n !== 1) begin errors++; $display("FAIL illegal_latency: got %0d want 1", n); end
    checks++;
    if (x !== 4'b0000 || y !== 4'b0000 || e !== 1'b1) begin
      errors++; $display("FAIL illegal_result: got x=%b y=%b err=%b want 0000/0000/1", x, y, e);
    end
    @(posedge clk); #1;
    do_op(4'b0011, 4'b0101, 2'd1, n, x, y, e);
    checks++;
    if (x !== 4'b1110 || y !== 4'b1000 || e !== 1'b0) begin
      errors++; $display("FAIL after_illegal_result: got x=%b y=%b err=%b want 1110/1000/0", x, y, e);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    int n; logic [3:0] x, y; logic e;
    rsp_ready = 1'b0;
    do_op(4'b0110, 4'b1010, 2'd0, n, x, y, e);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_x !== 4'b0010 || rsp_y !== 4'b1110 || rsp_err !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got valid=%b ready=%b x=%b y=%b err=%b want 1/0/0010/1110/0",
                 i, rsp_valid, req_ready, rsp_x, rsp_y, rsp_err);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL stall_release: got valid=%b ready=%b want 0/1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset_busy();
    logic seen;
    req_valid = 1'b1; req_a = 4'b0110; req_b = 4'b1010; req_op = 2'd0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_busy_async: got valid=%b ready=%b want 0/1", rsp_valid, req_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL reset_busy_no_rsp: got seen=%b want 0", seen); end
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_busy_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_back_to_back();
    int n;
    req_valid = 1'b1; req_a = 4'b0110; req_b = 4'b1010; req_op = 2'd0;
    @(posedge clk); #1;
    req_op = 2'd1;
    n = 1;
    while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    checks++;
    if (n !== 5 || rsp_x !== 4'b0010 || rsp_y !== 4'b1110) begin
      errors++; $display("FAIL b2b_first: got n=%0d x=%b y=%b want 5/0010/1110", n, rsp_x, rsp_y);
    end
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle_gap: got ready=%b want 1", req_ready); end
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_second_accept: got ready=%b want 0", req_ready); end
    req_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    checks++;
    if (n !== 5 || rsp_x !== 4'b1101 || rsp_y !== 4'b0001 || rsp_err !== 1'b0) begin
      errors++; $display("FAIL b2b_second: got n=%0d x=%b y=%b err=%b want 5/1101/0001/0", n, rsp_x, rsp_y, rsp_err);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_andor();
    test_nandnor();
    test_xorxnor();
    test_illegal();
    test_stall();
    test_reset_busy();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
